board_scanner: RTL and testbench



---
 rtl/board_scan_if.sv | 28 ++
 rtl/board_scanner.sv | 139 +++++++++++++
 tb/tb_board_scanner.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/board_scan_if.sv
// Board scan bus: the composited board in, the row/column drive and the
// end-of-frame strobe out.
//   enable      start/continue scanning
//   board_data  board_data[i] is row i (row 0 is the top row)
//   row_sel     one-hot row drive, bit i drives board row i
//   col_data    column pattern for the selected row
//   frame_done  one-cycle pulse after the last row's final dwell cycle
// master: board source / display consumer side; slave: the scanner.
interface board_scan_if #(
  parameter int board_width  = 9,
  parameter int board_height = 16
);
  logic                                     enable;
  logic [0:board_height-1][board_width-1:0] board_data;
  logic [board_height-1:0]                  row_sel;
  logic [board_width-1:0]                   col_data;
  logic                                     frame_done;

  modport master (
    output enable, board_data,
    input  row_sel, col_data, frame_done
  );

  modport slave (
    input  enable, board_data,
    output row_sel, col_data, frame_done
  );
endinterface

// File: rtl/board_scanner.sv
// Display-side reader of the composited game board. Snapshots the whole board
// at frame start and scans it out row by row (one-hot row select plus column
// pattern), inserting an all-off blanking gap between rows against ghosting.
// frame_done pulses once per frame so board updates can follow frame bounds.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high
//   bus    board_scan_if slave (enable, board_data in; row_sel, col_data,
//          frame_done out, all registered)
//
// state | meaning
// IDLE  | outputs off, waiting for enable
// LATCH | one cycle: snapshot board_data, restart at row 0
// BLANK | blank_cycles of all-off between rows
// SHOW  | dwell_cycles driving row row_idx with its snapshot pattern
module board_scanner #(
  parameter int board_width  = 9,
  parameter int board_height = 16,
  parameter int dwell_cycles = 4,
  parameter int blank_cycles = 1
) (
  input  logic         clk,
  input  logic         reset,
  board_scan_if.slave  bus
);

  localparam int max_dw_bl = (dwell_cycles > blank_cycles) ? dwell_cycles : blank_cycles;
  localparam int max_all   = (max_dw_bl > board_height) ? max_dw_bl : board_height;
  localparam int cnt_w     = (max_all > 1) ? $clog2(max_all) : 1;
  localparam int row_w     = (board_height > 1) ? $clog2(board_height) : 1;

  // Phase counter counts down to zero; zero marks the last cycle of a phase.
  localparam logic [cnt_w-1:0] dwell_load = cnt_w'(dwell_cycles - 1);
  localparam logic [cnt_w-1:0] blank_load = cnt_w'((blank_cycles > 0) ? blank_cycles - 1 : 0);
  localparam logic [row_w-1:0] last_row   = row_w'(board_height - 1);

  typedef enum logic [1:0] {IDLE, LATCH, BLANK, SHOW} state_t;

  state_t                                   state, state_d;
  logic [row_w-1:0]                         row_idx, row_d;
  logic [cnt_w-1:0]                         cnt, cnt_d;
  logic [0:board_height-1][board_width-1:0] snapshot;
  logic                                     snap_load;
  logic [board_height-1:0]                  row_sel_q, row_sel_d;
  logic [board_width-1:0]                   col_q, col_d;
  logic                                     frame_done_q, frame_done_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      row_idx      <= '0;
      cnt          <= '0;
      row_sel_q    <= '0;
      col_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state        <= state_d;
      row_idx      <= row_d;
      cnt          <= cnt_d;
      row_sel_q    <= row_sel_d;
      col_q        <= col_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Snapshot content is don't-care after reset, so it carries no reset.
  always_ff @(posedge clk) begin
    if (snap_load) snapshot <= bus.board_data;
  end

  always_comb begin
    state_d      = state;
    row_d        = row_idx;
    cnt_d        = cnt;
    snap_load    = 1'b0;
    frame_done_d = 1'b0;

    case (state)
      IDLE: begin
        if (bus.enable) state_d = LATCH;
      end
      LATCH: begin
        snap_load = 1'b1;
        row_d     = '0;
        if (blank_cycles > 0) begin
          state_d = BLANK;
          cnt_d   = blank_load;
        end else begin
          state_d = SHOW;
          cnt_d   = dwell_load;
        end
      end
      BLANK: begin
        if (cnt == '0) begin
          state_d = SHOW;
          cnt_d   = dwell_load;
        end else begin
          cnt_d = cnt - cnt_w'(1);
        end
      end
      SHOW: begin
        if (cnt != '0) begin
          cnt_d = cnt - cnt_w'(1);
        end else if (row_idx == last_row) begin
          frame_done_d = 1'b1;
          row_d        = '0;
          cnt_d        = '0;
          state_d      = bus.enable ? LATCH : IDLE;
        end else begin
          row_d = row_idx + row_w'(1);
          if (blank_cycles > 0) begin
            state_d = BLANK;
            cnt_d   = blank_load;
          end else begin
            state_d = SHOW;
            cnt_d   = dwell_load;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered alongside the state, so they are decoded from
    // the next state. With no blanking, LATCH goes straight to SHOW and the
    // snapshot is being written on that same edge, so row 0 comes straight
    // from board_data.
    row_sel_d = '0;
    col_d     = '0;
    if (state_d == SHOW) begin
      row_sel_d[row_d] = 1'b1;
      col_d            = snap_load ? bus.board_data[row_d] : snapshot[row_d];
    end
  end

  assign bus.row_sel    = row_sel_q;
  assign bus.col_data   = col_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_board_scanner.sv
module tb_board_scanner;
  localparam int W = 9;
  localparam int H = 16;
  typedef logic [0:H-1][W-1:0] board_t;

  typedef struct {
    int              cyc;
    logic [H-1:0]    rs;
    logic [W-1:0]    col;
    logic            fd;
  } exp_t;

  logic clk = 1'b0;
  logic reset, reset2;
  int   cyc = 0;
  int   base = 0;
  int   base2 = 0;
  int   checks = 0;
  int   errors = 0;
  bit   done2 = 1'b0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  board_scan_if #(.board_width(W), .board_height(H)) bus0 ();
  board_scan_if #(.board_width(W), .board_height(H)) bus1 ();

  board_scanner #(.board_width(W), .board_height(H), .dwell_cycles(4), .blank_cycles(1))
    u_dut (.clk(clk), .reset(reset), .bus(bus0));

  board_scanner #(.board_width(W), .board_height(H), .dwell_cycles(2), .blank_cycles(0))
    u_dut2 (.clk(clk), .reset(reset2), .bus(bus1));

  task automatic push_exp(int which, int c, logic [H-1:0] rs, logic [W-1:0] col, logic fd);
    exp_t e;
    e.cyc = c; e.rs = rs; e.col = col; e.fd = fd;
    if (which == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic push_zero(int which, int b, int from, int to, bit fd_first);
    for (int k = from; k <= to; k++)
      push_exp(which, b + k, '0, '0, (k == from) ? fd_first : 1'b0);
  endtask

  // Frame timeline, j = edges since the LATCH edge: j=0 LATCH, then for each
  // row blank_cycles off followed by dwell_cycles showing that row.
  task automatic push_frame(int which, int b, int s, int last, board_t d,
                            bit fd_first, int dwell, int blank);
    for (int k = s; k <= last; k++) begin
      int j;
      int t;
      int r;
      int ph;
      j = k - s;
      if (j == 0) begin
        push_exp(which, b + k, '0, '0, fd_first);
      end else begin
        t  = j - 1;
        r  = t / (dwell + blank);
        ph = t % (dwell + blank);
        if (ph < blank) push_exp(which, b + k, '0, '0, 1'b0);
        else            push_exp(which, b + k, H'(1) << r, d[r], 1'b0);
      end
    end
  endtask

  task automatic check_item(string nm, int c, exp_t e, logic [H-1:0] rs,
                            logic [W-1:0] col, logic fd);
    checks++;
    if (rs !== e.rs || col !== e.col || fd !== e.fd) begin
      errors++;
      $display("FAIL %s cyc=%0d row_sel=%h want %h col_data=%h want %h frame_done=%b want %b",
               nm, c, rs, e.rs, col, e.col, fd, e.fd);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    checks++;
    if (!$onehot0(bus0.row_sel)) begin
      errors++;
      $display("FAIL scan0_onehot cyc=%0d row_sel=%h want at most one bit", cyc, bus0.row_sel);
    end
    while (q0.size() > 0 && q0[0].cyc < cyc) begin
      e = q0.pop_front();
      checks++; errors++;
      $display("FAIL scan0_missed cyc=%0d expectation never compared, now %0d", e.cyc, cyc);
    end
    if (q0.size() > 0 && q0[0].cyc == cyc) begin
      e = q0.pop_front();
      check_item("scan0", cyc, e, bus0.row_sel, bus0.col_data, bus0.frame_done);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    checks++;
    if (!$onehot0(bus1.row_sel)) begin
      errors++;
      $display("FAIL scan1_onehot cyc=%0d row_sel=%h want at most one bit", cyc, bus1.row_sel);
    end
    while (q1.size() > 0 && q1[0].cyc < cyc) begin
      e = q1.pop_front();
      checks++; errors++;
      $display("FAIL scan1_missed cyc=%0d expectation never compared, now %0d", e.cyc, cyc);
    end
    if (q1.size() > 0 && q1[0].cyc == cyc) begin
      e = q1.pop_front();
      check_item("scan1", cyc, e, bus1.row_sel, bus1.col_data, bus1.frame_done);
    end
  end

  task automatic wait_edge(int k);
    while (cyc < base + k) @(negedge clk);
  endtask

  // Main scanner: dwell 4, blank 1.
  initial begin
    board_t pa, pb, pc, pd;
    for (int i = 0; i < H; i++) begin
      pa[i] = (i % 2 == 0) ? 9'h1FF : 9'h000;
      pc[i] = 9'(i * 37 + 5);
      pd[i] = ~pc[i];
    end
    pb     = pa;
    pb[15] = 9'h155;

    reset = 1'b1;
    bus0.enable = 1'b0;
    bus0.board_data = '0;
    push_zero(0, 0, 1, 4, 1'b0);
    while (cyc < 4) @(negedge clk);
    reset = 1'b0;
    base  = cyc;
    push_zero(0, base, 1, 20, 1'b0);
    wait_edge(20);

    // Frame 1 with the even/odd pattern; frame 2 picks up the row-15 change
    // made mid-frame-1; enable drops mid-frame-2 so the bus goes idle after.
    bus0.board_data = pa;
    bus0.enable = 1'b1;
    base = cyc;
    push_frame(0, base, 1, 81, pa, 1'b0, 4, 1);
    push_frame(0, base, 82, 162, pb, 1'b1, 4, 1);
    push_zero(0, base, 163, 180, 1'b1);
    wait_edge(39);
    bus0.board_data = pb;
    wait_edge(110);
    bus0.enable = 1'b0;
    wait_edge(180);

    // Reset pulse, then reset hitting during row 9 and a clean restart.
    reset = 1'b1;
    push_zero(0, base, 181, 182, 1'b0);
    wait_edge(182);
    reset = 1'b0;
    bus0.enable = 1'b1;
    bus0.board_data = pc;
    base = cyc;
    push_frame(0, base, 1, 49, pc, 1'b0, 4, 1);
    push_zero(0, base, 50, 51, 1'b0);
    wait_edge(49);
    reset = 1'b1;
    wait_edge(51);
    reset = 1'b0;
    bus0.board_data = pd;
    base = cyc;
    push_frame(0, base, 1, 81, pd, 1'b0, 4, 1);
    push_zero(0, base, 82, 90, 1'b1);
    wait_edge(10);
    bus0.enable = 1'b0;
    wait_edge(90);

    for (int i = 0; i < 500 && !done2; i++) @(negedge clk);
    checks++;
    if (!done2) begin
      errors++;
      $display("FAIL scan1_timeout second scanner sequence got done=%b want 1", done2);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL leftover expectations got %0d/%0d want 0/0", q0.size(), q1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Second scanner: dwell 2, no blanking, 33-cycle frame period.
  initial begin
    board_t pe, pf;
    for (int i = 0; i < H; i++) begin
      pe[i] = 9'(i * 11 + 1);
      pf[i] = 9'(i * 29 + 100);
    end
    reset2 = 1'b1;
    bus1.enable = 1'b0;
    bus1.board_data = pe;
    push_zero(1, 0, 1, 3, 1'b0);
    while (cyc < 3) @(negedge clk);
    reset2 = 1'b0;
    bus1.enable = 1'b1;
    base2 = cyc;
    push_frame(1, base2, 1, 33, pe, 1'b0, 2, 0);
    push_frame(1, base2, 34, 66, pf, 1'b1, 2, 0);
    push_zero(1, base2, 67, 70, 1'b1);
    while (cyc < base2 + 19) @(negedge clk);
    bus1.board_data = pf;
    while (cyc < base2 + 39) @(negedge clk);
    bus1.enable = 1'b0;
    while (cyc < base2 + 70) @(negedge clk);
    done2 = 1'b1;
  end
endmodule
